bless_inject: RTL and testbench

Local injection port for a bufferless (BLESS) mesh router. It accepts packets from the local resource and holds them in a small FIFO with per-entry age. It builds the 13-bit control word that the router's route-compute stage consumes and injects one flit whenever the router reports a free input slot. Packets addressed to the node itself are looped back locally and never enter the network.

---
 rtl/bless_inject.sv | 157 +++++++++++++++
 tb/tb_bless_inject.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bless_inject.sv
//==============================================================================
// Module   : bless_inject
// Purpose  : Local injection port for a bufferless mesh router: aged FIFO,
//            route-compute control word, self-addressed loopback.
// Revision : 1.0
//==============================================================================
`default_nettype none

module bless_inject #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               addrx,
  input  logic [1:0]               addry,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_destx,
  input  logic [1:0]               req_desty,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     slot_free,
  output logic                     inj_valid,
  output logic [12:0]              inj_control,
  output logic [DATA_W-1:0]        inj_data,
  output logic                     loop_valid,
  output logic [DATA_W-1:0]        loop_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] c_full    = CW'(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [3:0]    c_age_max = 4'hF;

  // Per-entry storage
  logic [1:0]        r_destx [DEPTH];
  logic [1:0]        r_desty [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [3:0]        r_age   [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              r_inj_valid;
  logic [12:0]       r_inj_control;
  logic [DATA_W-1:0] r_inj_data;
  logic              r_loop_valid;
  logic [DATA_W-1:0] r_loop_data;

  logic              w_push;
  logic              w_pop;
  logic              w_not_empty;
  logic              w_head_local;
  logic [1:0]        w_head_destx;
  logic [1:0]        w_head_desty;
  logic [DATA_W-1:0] w_head_data;
  logic [3:0]        w_head_age_inc;

  assign req_ready   = (r_count != c_full);
  assign w_not_empty = (r_count != '0);
  assign w_push      = req_valid && req_ready;

  assign w_head_destx = r_destx[r_rd_ptr];
  assign w_head_desty = r_desty[r_rd_ptr];
  assign w_head_data  = r_data[r_rd_ptr];

  // The flit reports the age it reaches at the pop edge itself.
  assign w_head_age_inc = (r_age[r_rd_ptr] == c_age_max) ? c_age_max
                                                          : r_age[r_rd_ptr] + 4'd1;

  assign w_head_local = ({w_head_destx, w_head_desty} == {addrx, addry});

  // A local head drains regardless of the router; a network head waits for a slot.
  assign w_pop = w_not_empty && (w_head_local || slot_free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_destx[i] <= '0;
        r_desty[i] <= '0;
        r_data[i]  <= '0;
        r_age[i]   <= '0;
      end
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && (r_age[i] != c_age_max)) begin
          r_age[i] <= r_age[i] + 4'd1;
        end
        if (w_push && (r_wr_ptr == AW'(i))) begin
          r_destx[i] <= req_destx;
          r_desty[i] <= req_desty;
          r_data[i]  <= req_data;
          r_age[i]   <= 4'd0;
        end
      end

      // Push and pop never target the same slot: push needs a free slot, pop an occupied one.
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + c_ptr_one;
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inj_valid   <= 1'b0;
      r_inj_control <= '0;
      r_inj_data    <= '0;
      r_loop_valid  <= 1'b0;
      r_loop_data   <= '0;
    end else begin
      r_inj_valid   <= 1'b0;
      r_inj_control <= '0;
      r_inj_data    <= '0;
      r_loop_valid  <= 1'b0;
      r_loop_data   <= '0;
      if (w_pop && w_head_local) begin
        r_loop_valid <= 1'b1;
        r_loop_data  <= w_head_data;
      end else if (w_pop) begin
        r_inj_valid   <= 1'b1;
        r_inj_control <= {1'b1, addrx, addry, w_head_destx, w_head_desty, w_head_age_inc};
        r_inj_data    <= w_head_data;
      end
    end
  end

  assign inj_valid   = r_inj_valid;
  assign inj_control = r_inj_control;
  assign inj_data    = r_inj_data;
  assign loop_valid  = r_loop_valid;
  assign loop_data   = r_loop_data;
  assign occupancy   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bless_inject.sv
//==============================================================================
// Module   : tb_bless_inject
// Purpose  : Self-checking bench for bless_inject (vector table + sequences).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_bless_inject;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addrx, addry;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_destx, req_desty;
  logic [31:0] req_data;
  logic        slot_free;
  logic        inj_valid;
  logic [12:0] inj_control;
  logic [31:0] inj_data;
  logic        loop_valid;
  logic [31:0] loop_data;
  logic [2:0]  occupancy;

  int n_pass  = 0;
  int n_total = 0;

  bless_inject #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addrx(addrx), .addry(addry),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_destx(req_destx), .req_desty(req_desty), .req_data(req_data),
    .slot_free(slot_free), .inj_valid(inj_valid), .inj_control(inj_control),
    .inj_data(inj_data), .loop_valid(loop_valid), .loop_data(loop_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rv;
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [31:0] d;
    logic        sf;
    logic [2:0]  occ;
    logic        rdy;
    logic        iv;
    logic [12:0] ic;
    logic [31:0] id;
    logic        lv;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [1:0] dx, input logic [1:0] dy,
                       input logic [31:0] d, input logic sf);
    req_valid = rv; req_destx = dx; req_desty = dy; req_data = d; slot_free = sf;
  endtask

  task automatic do_reset(input logic [1:0] ax, input logic [1:0] ay);
    drive(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    addrx = ax; addry = ay;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_occ"},  32'(occupancy),   32'd0);
    chk({tag, "_rdy"},  32'(req_ready),   32'd1);
    chk({tag, "_iv"},   32'(inj_valid),   32'd0);
    chk({tag, "_ic"},   32'(inj_control), 32'd0);
    chk({tag, "_id"},   inj_data,         32'd0);
    chk({tag, "_lv"},   32'(loop_valid),  32'd0);
    chk({tag, "_ld"},   loop_data,        32'd0);
  endtask

  initial begin
    // Node (1,2): basic inject, then NET / LOCAL / NET ordering.
    tbl[0] = '{1'b1, 2'd3, 2'd0, 32'hA5A5A5A5, 1'b1, 3'd1, 1'b1, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0};
    tbl[1] = '{1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 3'd0, 1'b1, 1'b1, 13'h16C1, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 2'd1, 2'd2, 32'h11111111, 1'b0, 3'd1, 1'b1, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0};
    tbl[3] = '{1'b1, 2'd0, 2'd3, 32'h22222222, 1'b0, 3'd1, 1'b1, 1'b0, 13'h0,    32'h0,        1'b1, 32'h11111111};
    tbl[4] = '{1'b0, 2'd0, 2'd0, 32'h0,        1'b0, 3'd1, 1'b1, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0};
    tbl[5] = '{1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 3'd0, 1'b1, 1'b1, 13'h1632, 32'h22222222, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 3'd0, 1'b1, 1'b0, 13'h0,    32'h0,        1'b0, 32'h0};

    rst = 1'b0;
    do_reset(2'd1, 2'd2);
    chk_idle("reset");

    for (int v = 0; v < 7; v++) begin
      drive(tbl[v].rv, tbl[v].dx, tbl[v].dy, tbl[v].d, tbl[v].sf);
      tick();
      chk($sformatf("v%0d_occ", v), 32'(occupancy),   32'(tbl[v].occ));
      chk($sformatf("v%0d_rdy", v), 32'(req_ready),   32'(tbl[v].rdy));
      chk($sformatf("v%0d_iv", v),  32'(inj_valid),   32'(tbl[v].iv));
      chk($sformatf("v%0d_ic", v),  32'(inj_control), 32'(tbl[v].ic));
      chk($sformatf("v%0d_id", v),  inj_data,         tbl[v].id);
      chk($sformatf("v%0d_lv", v),  32'(loop_valid),  32'(tbl[v].lv));
      chk($sformatf("v%0d_ld", v),  loop_data,        tbl[v].ld);
    end

    // Aging saturation from node (1,1).
    do_reset(2'd1, 2'd1);
    drive(1'b1, 2'd0, 2'd0, 32'h000000AA, 1'b0); tick();
    drive(1'b1, 2'd0, 2'd0, 32'h000000BB, 1'b0); tick();
    drive(1'b0, 2'd0, 2'd0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("age_hold_iv", 32'(inj_valid), 32'd0);
    slot_free = 1'b1;
    tick();
    chk("age_a_ic", 32'(inj_control), 32'h150F);
    chk("age_a_id", inj_data, 32'hAA);
    tick();
    chk("age_b_ic", 32'(inj_control), 32'h150F);
    chk("age_b_id", inj_data, 32'hBB);
    tick();
    chk("age_done_iv", 32'(inj_valid), 32'd0);

    // Full FIFO, then overlapping enqueue and pop.
    do_reset(2'd1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, 2'd3, 32'd100 + 32'(i), 1'b0);
      tick();
    end
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_rdy", 32'(req_ready), 32'd0);
    drive(1'b1, 2'd3, 2'd3, 32'd200, 1'b1);
    tick();
    chk("full_pop_occ", 32'(occupancy), 32'd3);
    chk("full_pop_id",  inj_data, 32'd100);
    chk("full_pop_ic",  32'(inj_control), 32'h16F4);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("full_ovl%0d_occ", i), 32'(occupancy), 32'd3);
      chk($sformatf("full_ovl%0d_id", i),  inj_data, 32'd100 + 32'(i));
    end

    // Reset mid-operation with three entries pending.
    do_reset(2'd1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 2'd1, 32'd300 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 2'd0, 32'h0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    rst = 1'b0;
    #1;
    chk_idle("mid_rst");
    #4;
    rst = 1'b1;
    slot_free = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d_iv", i),  32'(inj_valid), 32'd0);
      chk($sformatf("post_rst%0d_occ", i), 32'(occupancy), 32'd0);
    end

    // Streaming throughput: 8 packets, one flit per cycle.
    do_reset(2'd1, 2'd2);
    for (int k = 0; k < 10; k++) begin
      drive(k < 8, 2'd3, 2'd3, 32'h5000 + 32'(k), 1'b1);
      tick();
      chk($sformatf("tp%0d_occ", k), 32'(occupancy <= 3'd1), 32'd1);
      if (k >= 1 && k <= 8) begin
        chk($sformatf("tp%0d_iv", k), 32'(inj_valid), 32'd1);
        chk($sformatf("tp%0d_id", k), inj_data, 32'h5000 + 32'(k - 1));
        chk($sformatf("tp%0d_ic", k), 32'(inj_control), 32'h16F1);
      end else begin
        chk($sformatf("tp%0d_iv", k), 32'(inj_valid), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
